ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Receives raw PS/2 keyboard clock/data lines, deserialises 11-bit frames,
//  parses Set-2 prefix bytes (E0/F0/E1) and emits one key event per make/break.
//  Sits directly upstream of the keycode-to-ASCII resolver: device_code and
//  shift_pressed feed it; is_break/is_extended go to the key-event consumer.
// PARAMETERS
//  FILTER_LEN     4      cycles ps2_clk_s must stay stable before an edge counts
//  TIMEOUT_CYCLES 50000  idle clk cycles mid-frame before the frame is aborted (~1ms@50MHz)
// PORTS
//  clk           in   1  system clock; the only clock domain
//  rst           in   1  asynchronous, active-high reset
//  ps2_clk       in   1  raw PS/2 clock, asynchronous to clk
//  ps2_data      in   1  raw PS/2 data, asynchronous to clk
//  key_valid     out  1  one-cycle pulse: device_code/flags below are valid
//  device_code   out  8  scan code of the key (prefixes stripped)
//  is_break      out  1  1 = key release (F0 seen), 0 = press
//  is_extended   out  1  1 = E0 prefix preceded this code
//  shift_pressed out  1  level: left (12) or right (59) shift held, non-extended
//  frame_err     out  1  one-cycle pulse: bad start/stop/parity or timeout
// BEHAVIOUR
//  Reset: every output 0; both FSMs idle; shift tracking cleared; filters
//   preloaded to 1 (line idle). Reset mid-frame discards the partial frame.
//  Input: 2-FF synchroniser on both lines; ps2_clk_s passes a FILTER_LEN-cycle
//   stability filter; a filtered 1->0 transition yields a one-cycle fall strobe;
//   ps2_data_s is sampled on that strobe.
//  Frame FSM (RX_IDLE, RX_BITS): bit0 start must be 0; 8 data bits LSB first;
//   odd parity (data+parity has odd number of 1s); stop must be 1.
//   - start bit 1 on a fall: ignored, stay RX_IDLE (no error).
//   - after 11th bit: good -> byte strobe with byte; bad parity/stop -> frame_err.
//   - timeout counter reset on every fall; reaching TIMEOUT_CYCLES in RX_BITS
//     -> frame_err, back to RX_IDLE, bit count 0. Counter saturates, no wrap.
//  Byte FSM (S_BASE, S_E0, S_F0, S_E0F0, S_SKIP), advanced only on byte strobe:
//   - S_BASE: E0->S_E0; F0->S_F0; E1->S_SKIP with skip count 7;
//     AA/FA/FE/EE/00/FF (BAT/ack/resend/echo/overrun) consumed, no event;
//     else event {code, brk=0, ext=0}.
//   - S_E0: F0->S_E0F0; E0 stays; else event {code,0,1} -> S_BASE.
//   - S_F0: event {code,1,0} -> S_BASE.  S_E0F0: event {code,1,1} -> S_BASE.
//   - S_SKIP: drop byte, decrement count; count 0 -> S_BASE (Pause never emitted).
//   - frame_err in any byte state returns byte FSM to S_BASE.
//  Event timing: key_valid asserts the cycle after the byte strobe; device_code,
//   is_break, is_extended update in that same cycle and hold until next event.
//  shift_pressed: set/cleared on the event cycle for non-extended 12/59 make/
//   break; = L_held | R_held; updates the same cycle as the event it decodes,
//   so a shift event reports its own new state. Extended E0 12 (fake shift)
//   ignored. Not cleared by frame_err.
//  Byte strobe and fall strobe cannot coincide with key_valid of the same byte;
//   back-to-back frames need no stall (no backpressure; consumer must accept
//   each pulse).
// STRUCTURE
//  Shared package/header: PS2_PREFIX_E0=8'hE0, PS2_PREFIX_F0=8'hF0,
//   PS2_PREFIX_E1=8'hE1, PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59, reply codes
//   AA/FA/FE/EE, byte-FSM state encodings.
//  Sub-module ps2_rx_frame: synchroniser, filter, frame FSM, timeout;
//   outputs byte[7:0], byte_stb, frame_err. Top holds byte FSM and shift state.
// TESTING
//  1 Frame 0x1C (parity 0) -> one key_valid, device_code=1C, brk=0, ext=0.
//  2 Frames F0,1C -> single event after 2nd frame: 1C, brk=1, ext=0.
//  3 Frames E0,F0,75 -> single event 75, brk=1, ext=1; no event on prefixes.
//  4 12, 1C, F0 12, 1C -> shift_pressed 1 on first two events, 0 on last two.
//  5 0x1C with parity 1 -> frame_err pulse, no key_valid; next good frame decodes.
//  6 Stop after 5 bits >TIMEOUT_CYCLES -> frame_err, RX_IDLE; rst pulse mid-frame
//    -> all outputs 0, next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_scancode_decoder_pkg: Set-2 prefix/reply codes and FSM state encodings
package ps2_scancode_decoder_pkg;
   localparam logic [7:0] PS2_PREFIX_E0 = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_F0 = 8'hF0;
   localparam logic [7:0] PS2_PREFIX_E1 = 8'hE1;
   localparam logic [7:0] PS2_LSHIFT    = 8'h12;
   localparam logic [7:0] PS2_RSHIFT    = 8'h59;
   localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
   localparam logic [7:0] PS2_ACK       = 8'hFA;
   localparam logic [7:0] PS2_RESEND    = 8'hFE;
   localparam logic [7:0] PS2_ECHO      = 8'hEE;
   localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

   typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;
   typedef enum logic [2:0] {S_BASE, S_E0, S_F0, S_E0F0, S_SKIP} byte_state_t;

   function automatic logic is_reply(input logic [7:0] b);
      return b inside {PS2_BAT_OK, PS2_ACK, PS2_RESEND, PS2_ECHO, 8'h00, 8'hFF};
   endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: raw PS/2 lines in, decoded key events out
interface ps2_scancode_decoder_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       key_valid;
   logic [7:0] device_code;
   logic       is_break;
   logic       is_extended;
   logic       shift_pressed;
   logic       frame_err;
   modport master(output ps2_clk, ps2_data,
                  input key_valid, device_code, is_break, is_extended, shift_pressed, frame_err);
   modport slave(input ps2_clk, ps2_data,
                 output key_valid, device_code, is_break, is_extended, shift_pressed, frame_err);
endinterface

// File: rtl/ps2_scancode_decoder_rx_frame.sv
// ps2_rx_frame: synchronises and filters the PS/2 lines, deserialises 11-bit
// frames and flags bad start/parity/stop or mid-frame timeouts.
module ps2_rx_frame
   import ps2_scancode_decoder_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       byte_stb,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]    clk_sync, data_sync;
   logic          filt;
   logic [FW-1:0] fcnt;
   logic [TW-1:0] tmo;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;
   rx_state_t     st, nxt;
   logic          clk_s, data_s, settled, fall, tmo_hit, good, stb_d, err_d;

   assign clk_s   = clk_sync[1];
   assign data_s  = data_sync[1];
   assign settled = fcnt == FW'(FILTER_LEN - 1);
   assign fall    = filt & ~clk_s & settled;
   assign tmo_hit = tmo == TW'(TIMEOUT_CYCLES - 1);
   // shreg holds d0..d7 and parity; odd parity means their XOR is 1
   assign good    = data_s & ^shreg;

   always_ff @(posedge clk or posedge rst)
      if (rst) st <= RX_IDLE;
      else     st <= nxt;

   always_comb begin
      nxt   = st;
      stb_d = 1'b0;
      err_d = 1'b0;
      if (st == RX_IDLE) nxt = (fall && !data_s) ? RX_BITS : RX_IDLE;
      else if (fall && bit_cnt == 4'd9) begin
         nxt   = RX_IDLE;
         stb_d = good;
         err_d = !good;
      end else if (!fall && tmo_hit) begin
         nxt   = RX_IDLE;
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         filt      <= 1'b1;
         fcnt      <= '0;
         tmo       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         data      <= '0;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         fcnt      <= (clk_s == filt || settled) ? '0 : fcnt + 1'b1;
         filt      <= (clk_s != filt && settled) ? clk_s : filt;
         tmo       <= (st == RX_IDLE || fall) ? '0 : (tmo == TW'(TIMEOUT_CYCLES)) ? tmo : tmo + 1'b1;
         bit_cnt   <= (st == RX_IDLE || nxt == RX_IDLE) ? '0 : fall ? bit_cnt + 4'd1 : bit_cnt;
         shreg     <= (st == RX_BITS && fall) ? {data_s, shreg[8:1]} : shreg;
         data      <= stb_d ? shreg[7:0] : data;
         byte_stb  <= stb_d;
         frame_err <= err_d;
      end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: parses Set-2 prefix bytes into make/break key events
// and tracks the non-extended shift keys.
module ps2_scancode_decoder
   import ps2_scancode_decoder_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic                  clk,
   input logic                  rst,
   ps2_scancode_decoder_if.slave bus
);
   logic [7:0]  rx_byte, device_code;
   logic        byte_stb, frame_err, ev, brk, ext;
   logic        key_valid, is_break, is_extended, l_held, r_held;
   logic [2:0]  skip, skip_nxt;
   byte_state_t st, nxt;

   ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk(clk), .rst(rst), .ps2_clk(bus.ps2_clk), .ps2_data(bus.ps2_data),
      .data(rx_byte), .byte_stb(byte_stb), .frame_err(frame_err)
   );

   assign bus.key_valid     = key_valid;
   assign bus.device_code   = device_code;
   assign bus.is_break      = is_break;
   assign bus.is_extended   = is_extended;
   assign bus.shift_pressed = l_held | r_held;
   assign bus.frame_err     = frame_err;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st   <= S_BASE;
         skip <= '0;
      end else begin
         st   <= nxt;
         skip <= skip_nxt;
      end

   always_comb begin
      nxt      = st;
      skip_nxt = skip;
      ev       = 1'b0;
      brk      = 1'b0;
      ext      = 1'b0;
      if (frame_err) nxt = S_BASE;
      else if (byte_stb)
         case (st)
            S_BASE:
               if (rx_byte == PS2_PREFIX_E0) nxt = S_E0;
               else if (rx_byte == PS2_PREFIX_F0) nxt = S_F0;
               else if (rx_byte == PS2_PREFIX_E1) begin
                  nxt      = S_SKIP;
                  skip_nxt = PS2_PAUSE_TAIL;
               end else ev = !is_reply(rx_byte);
            S_E0:
               if (rx_byte == PS2_PREFIX_F0) nxt = S_E0F0;
               else if (rx_byte != PS2_PREFIX_E0) begin
                  ev  = 1'b1;
                  ext = 1'b1;
                  nxt = S_BASE;
               end
            S_F0: begin
               ev  = 1'b1;
               brk = 1'b1;
               nxt = S_BASE;
            end
            S_E0F0: begin
               ev  = 1'b1;
               brk = 1'b1;
               ext = 1'b1;
               nxt = S_BASE;
            end
            default: begin
               skip_nxt = skip - 3'd1;
               nxt      = (skip == 3'd1) ? S_BASE : S_SKIP;
            end
         endcase
   end

   // shift state changes on the same edge as key_valid so the event sees it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         key_valid   <= 1'b0;
         device_code <= '0;
         is_break    <= 1'b0;
         is_extended <= 1'b0;
         l_held      <= 1'b0;
         r_held      <= 1'b0;
      end else begin
         key_valid   <= ev;
         device_code <= ev ? rx_byte : device_code;
         is_break    <= ev ? brk : is_break;
         is_extended <= ev ? ext : is_extended;
         l_held      <= (ev && !ext && rx_byte == PS2_LSHIFT) ? !brk : l_held;
         r_held      <= (ev && !ext && rx_byte == PS2_RSHIFT) ? !brk : r_held;
      end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: table of PS/2 frames with a scoreboard of expected
// key events, plus hand sequences for spurious falls, timeout and reset.
module tb_ps2_scancode_decoder;
   localparam int TMO = 1000;
   typedef struct packed {logic [7:0] code; logic brk, ext, sh;} exp_t;
   typedef struct {logic [7:0] b; logic bad; logic [3:0] f;} vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   exp_t e;
   vec_t v[$];
   int   checks = 0, errors = 0, err_seen = 0, e0;

   always #5 clk = ~clk;

   ps2_scancode_decoder_if bus();
   ps2_scancode_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.frame_err) err_seen++;
      if (bus.key_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL event: unexpected code %0h", bus.device_code);
         end else begin
            e = q.pop_front();
            chk("event", {bus.device_code, bus.is_break, bus.is_extended, bus.shift_pressed}, e);
         end
      end
   end

   task automatic bit_tx(input logic d);
      bus.ps2_data = d;
      repeat (20) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic frame_tx(input logic [7:0] b, input logic bad, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, ~^b ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) bit_tx(fr[i]);
      bus.ps2_data = 1'b1;
      repeat (40) @(posedge clk);
   endtask

   task automatic add(input logic [7:0] b, input logic bad, input logic [3:0] f);
      vec_t r;
      r.b = b; r.bad = bad; r.f = f;
      v.push_back(r);
   endtask

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", {bus.key_valid, bus.device_code, bus.is_break, bus.is_extended,
                               bus.shift_pressed, bus.frame_err}, 0);
      @(negedge clk) rst = 1'b0;
      // f = {event, break, extended, shift_pressed}
      add(8'h1C, 1'b0, 4'b1000);
      add(8'hF0, 1'b0, 4'b0000); add(8'h1C, 1'b0, 4'b1100);
      add(8'hE0, 1'b0, 4'b0000); add(8'hF0, 1'b0, 4'b0000); add(8'h75, 1'b0, 4'b1110);
      add(8'h12, 1'b0, 4'b1001); add(8'h1C, 1'b0, 4'b1001);
      add(8'hF0, 1'b0, 4'b0000); add(8'h12, 1'b0, 4'b1100); add(8'h1C, 1'b0, 4'b1000);
      add(8'h1C, 1'b1, 4'b0000); add(8'h1C, 1'b0, 4'b1000);
      add(8'hAA, 1'b0, 4'b0000); add(8'hFA, 1'b0, 4'b0000);
      add(8'hE1, 1'b0, 4'b0000);
      add(8'h14, 1'b0, 4'b0000); add(8'h77, 1'b0, 4'b0000); add(8'hE1, 1'b0, 4'b0000);
      add(8'hF0, 1'b0, 4'b0000); add(8'h14, 1'b0, 4'b0000); add(8'hF0, 1'b0, 4'b0000);
      add(8'h77, 1'b0, 4'b0000); add(8'h1C, 1'b0, 4'b1000);
      add(8'hE0, 1'b0, 4'b0000); add(8'h12, 1'b0, 4'b1010);
      add(8'hE0, 1'b0, 4'b0000); add(8'hE0, 1'b0, 4'b0000); add(8'h75, 1'b0, 4'b1010);
      add(8'h59, 1'b0, 4'b1001);
      add(8'hE0, 1'b0, 4'b0000); add(8'hF0, 1'b0, 4'b0000); add(8'h12, 1'b0, 4'b1111);
      add(8'hF0, 1'b0, 4'b0000); add(8'h59, 1'b0, 4'b1100);
      foreach (v[i]) begin
         if (v[i].f[3]) q.push_back({v[i].b, v[i].f[2:0]});
         e0 = err_seen;
         frame_tx(v[i].b, v[i].bad, 11);
         chk("frame_err", err_seen - e0, {31'd0, v[i].bad});
         chk("pending", q.size(), 0);
      end
      e0 = err_seen;
      bit_tx(1'b1);
      repeat (40) @(posedge clk);
      chk("spurious_start", err_seen - e0, 0);
      frame_tx(8'h1C, 1'b0, 5);
      repeat (500) @(posedge clk);
      chk("timeout_early", err_seen - e0, 0);
      repeat (TMO) @(posedge clk);
      chk("timeout", err_seen - e0, 1);
      q.push_back({8'h23, 3'b000});
      frame_tx(8'h23, 1'b0, 11);
      chk("after_timeout", q.size(), 0);
      q.push_back({8'h12, 3'b001});
      frame_tx(8'h12, 1'b0, 11);
      chk("shift_before_rst", q.size(), 0);
      e0 = err_seen;
      frame_tx(8'h4D, 1'b0, 5);
      @(negedge clk) rst = 1'b1;
      #1 chk("mid_frame_reset", {bus.key_valid, bus.device_code, bus.is_break, bus.is_extended,
                                 bus.shift_pressed, bus.frame_err}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      q.push_back({8'h1C, 3'b000});
      frame_tx(8'h1C, 1'b0, 11);
      chk("after_reset", q.size(), 0);
      chk("reset_no_err", err_seen - e0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
